lc3_mem_ctrl: RTL
=================

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 16, giving the data word width; MMIO logic assumes 16.
REQ-002 The block SHALL have a parameter ADDR_WIDTH, default 16, giving the RAM address width passed to ram_generic.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  CPU address (MAR).
- req_wdata  in  16  write data (MDR).
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  16  read data.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_in_data  out  DATA_WIDTH  RAM write data.
- ram_out_data  in  DATA_WIDTH  RAM read data, valid after the edge that sampled ram_read.
- kb_valid  in  1  one-cycle keyboard character strobe.
- kb_char  in  8  keyboard character.
- disp_ready  in  1  display can take a character.
- disp_valid  out  1  one-cycle display strobe.
- disp_char  out  8  display character.

Function
REQ-005 The state machine SHALL have three states: IDLE, ACCESS and CAPTURE; req_ready SHALL be 1 only in IDLE with reset low.
REQ-006 A request SHALL be accepted at an edge where req_valid=1 and req_ready=1; the block SHALL latch addr, wdata and write, and go to ACCESS.
REQ-007 ACCESS SHALL last exactly one cycle.
  - RAM addresses (req_addr < 0xFE00): ram_address = latched addr[ADDR_WIDTH-1:0]; ram_in_data = wdata; exactly one of ram_read/ram_write = 1.
  - MMIO addresses: both strobes SHALL stay 0.
REQ-008 ACCESS SHALL always go to CAPTURE; CAPTURE SHALL always go to IDLE at the next edge.
REQ-009 At the CAPTURE→IDLE edge, resp_valid SHALL be set for exactly one cycle.
  - For reads, resp_rdata SHALL load the read value at that same edge.
  - For writes, resp_rdata SHALL hold its previous value.
  - Read latency: resp_valid is high in the cycle after the 3rd edge counting the accept edge as 1st.
REQ-010 A new request MAY be accepted in the same cycle resp_valid is high; back-to-back throughput SHALL be one request per 3 cycles.
REQ-011 Outside ACCESS, ram_read and ram_write SHALL be 0; ram_address and ram_in_data SHALL hold their last values.
REQ-012 MMIO map: the RAM SHALL never be strobed for 0xFE00–0xFFFF.
  - KBSR 0xFE00: read = {kb_full,15'b0}.
  - KBDR 0xFE02: read = {8'h00,kb_data}; clears kb_full.
  - DSR 0xFE04: read = {disp_ready,15'b0}, sampled in CAPTURE.
  - DDR 0xFE06: write only.
  - All other MMIO addresses: reads return 0x0000.
  - Writes to any MMIO address other than DDR SHALL be ignored but still acknowledged.
REQ-013 kb_valid while kb_full=0 SHALL load kb_data and set kb_full. kb_valid while kb_full=1 SHALL drop the character.
REQ-014 If kb_valid coincides with the CAPTURE edge of a KBDR read:
  - resp_rdata SHALL return the old character;
  - kb_data SHALL take the new character;
  - kb_full SHALL remain 1.
REQ-015 A DDR write SHALL pulse disp_valid for one cycle, aligned with resp_valid, with disp_char = wdata[7:0], only if disp_ready=1 in CAPTURE. Otherwise the character SHALL be dropped and still acknowledged.

Reset
REQ-016 At a reset edge the block SHALL set the following, discarding any in-flight request without a resp_valid pulse:
  - state = IDLE;
  - resp_valid = 0 and disp_valid = 0;
  - resp_rdata = 0 and disp_char = 0;
  - ram_address = 0 and ram_in_data = 0;
  - kb_full = 0 and kb_data = 0.
REQ-017 While reset=1, ram_read, ram_write and req_ready SHALL be forced to 0 combinationally, so no RAM write commits at a reset edge.

Verification
REQ-018 Bench scenario: write 0x3000 ← 0x1234, then read 0x3000 → resp_rdata = 0x1234, with resp_valid 3 edges after each accept and one ram_write pulse then one ram_read pulse.
REQ-019 Bench scenario: hold req_valid=1 for 4 reads of 0x0000–0x0003 preloaded with 100,102,104,106 → responses in order, accepts exactly 3 cycles apart.
REQ-020 Bench scenario: kb_valid with kb_char=0x41, then read KBSR → 0x8000; read KBDR → 0x0041; read KBSR → 0x0000; a second kb_valid while full is dropped.
REQ-021 Bench scenario: disp_ready=1 and write DDR 0x0F5A → disp_valid one cycle with disp_char=0x5A; with disp_ready=0 → no disp_valid, resp_valid still pulses, DSR reads 0x0000.
REQ-022 Bench scenario: write 0x0010 ← 0xBEEF, then reset high during its ACCESS cycle → no ram_write commit, no resp_valid; read 0x0010 after reset returns the preloaded old value.
REQ-023 Bench scenario: write 0xFE00 and read 0xFFFE → no RAM strobes, read returns 0x0000, both acknowledged.

Source files
------------

// File: rtl/lc3_mem_ctrl.sv
`timescale 1ns/1ps
// LC-3 memory controller: a three-state request FSM in front of a synchronous RAM,
// with the keyboard/display registers decoded in the 0xFE00-0xFFFF window.
module lc3_mem_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [15:0]           req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [15:0]           resp_rdata,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_in_data,
    input  logic [DATA_WIDTH-1:0] ram_out_data,
    input  logic                  kb_valid,
    input  logic [7:0]            kb_char,
    input  logic                  disp_ready,
    output logic                  disp_valid,
    output logic [7:0]            disp_char
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    logic [1:0]  state;
    logic [15:0] lat_addr;
    logic        lat_write;
    logic [7:0]  lat_char;
    logic        kb_full;
    logic [7:0]  kb_data;

    logic        accept;
    logic        in_access;
    logic        in_capture;
    logic        kbdr_read;
    logic        ddr_write;
    logic        kb_load;
    logic [15:0] rd_value;

    function automatic logic is_mmio(input logic [15:0] addr);
        return addr[15:9] == 7'h7F;
    endfunction

    assign req_ready  = !reset && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign in_access  = (state == ACCESS);
    assign in_capture = (state == CAPTURE);

    // Strobes are gated by reset so a write caught mid-ACCESS never commits.
    assign ram_read  = !reset && in_access && !is_mmio(lat_addr) && !lat_write;
    assign ram_write = !reset && in_access && !is_mmio(lat_addr) && lat_write;

    assign kbdr_read = in_capture && !lat_write && (lat_addr == KBDR_ADDR);
    assign ddr_write = in_capture && lat_write && (lat_addr == DDR_ADDR);
    assign kb_load   = kb_valid && (!kb_full || kbdr_read);

    always_comb begin
        rd_value = 16'h0000;
        if (!is_mmio(lat_addr)) begin
            rd_value = 16'(ram_out_data);
        end else begin
            case (lat_addr)
                KBSR_ADDR: rd_value = {kb_full, 15'b0};
                KBDR_ADDR: rd_value = {8'h00, kb_data};
                DSR_ADDR:  rd_value = {disp_ready, 15'b0};
                default:   rd_value = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= ACCESS;
                ACCESS:  state <= CAPTURE;
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_char  <= req_wdata[7:0];
        end
    end

    // RAM address/data only move on a RAM accept, so they hold between accesses.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_address <= '0;
            ram_in_data <= '0;
        end else if (accept && !is_mmio(req_addr)) begin
            ram_address <= ADDR_WIDTH'(req_addr);
            ram_in_data <= DATA_WIDTH'(req_wdata);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            disp_valid <= 1'b0;
            disp_char  <= 8'h00;
        end else begin
            resp_valid <= in_capture;
            disp_valid <= ddr_write && disp_ready;
            if (in_capture && !lat_write) resp_rdata <= rd_value;
            if (ddr_write && disp_ready) disp_char <= lat_char;
        end
    end

    // A KBDR read frees the slot at its capture edge, so a coincident key is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            kb_full <= 1'b0;
            kb_data <= 8'h00;
        end else if (kb_load) begin
            kb_full <= 1'b1;
            kb_data <= kb_char;
        end else if (kbdr_read) begin
            kb_full <= 1'b0;
        end
    end

endmodule
